// File: rtl/tone_sequencer.sv
// Tone sequencer: plays a fixed 4-step square-wave melody per sound type.
// Type 2 loops while enabled; the other types play once and park in DONE.
module tone_sequencer #(
  parameter int TONE_SCALE = 4096,
  parameter int NOTE_LEN   = 6250000,
  parameter int HW         = 20,
  parameter int NW         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] sound_type,
  output logic       audio,
  output logic       busy,
  output logic [1:0] step
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [NW-1:0] NOTE_LAST = NW'(NOTE_LEN - 1);

  logic [1:0]    state;
  logic [1:0]    cur_type;
  logic [NW-1:0] note_cnt;
  logic [HW-1:0] half_cnt;
  logic [HW-1:0] tgt;
  logic [7:0]    code;
  logic          note_end;
  logic          half_end;
  logic          changed;

  // half-period code, 0 means rest
  always_comb begin
    code = 8'd0;
    unique case ({cur_type, step})
      4'h0: code = 8'd40;
      4'h1: code = 8'd40;
      4'h2: code = 8'd0;
      4'h3: code = 8'd0;
      4'h4: code = 8'd60;
      4'h5: code = 8'd50;
      4'h6: code = 8'd40;
      4'h7: code = 8'd30;
      4'h8: code = 8'd30;
      4'h9: code = 8'd60;
      4'ha: code = 8'd30;
      4'hb: code = 8'd60;
      4'hc: code = 8'd80;
      4'hd: code = 8'd60;
      4'he: code = 8'd40;
      4'hf: code = 8'd20;
      default: code = 8'd0;
    endcase
  end

  assign tgt      = HW'(code) * HW'(TONE_SCALE);
  assign note_end = (note_cnt == NOTE_LAST);
  assign half_end = (half_cnt == tgt - HW'(1));
  assign changed  = (sound_type != cur_type);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cur_type <= 2'd0;
      note_cnt <= '0;
      half_cnt <= '0;
      audio    <= 1'b0;
      busy     <= 1'b0;
      step     <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            state    <= PLAY;
            cur_type <= sound_type;
            busy     <= 1'b1;
            step     <= 2'd0;
            note_cnt <= '0;
            half_cnt <= '0;
            audio    <= 1'b0;
          end
        end
        PLAY: begin
          if (!en) begin
            state    <= IDLE;
            busy     <= 1'b0;
            step     <= 2'd0;
            note_cnt <= '0;
            half_cnt <= '0;
            audio    <= 1'b0;
          end else if (changed) begin
            cur_type <= sound_type;
            step     <= 2'd0;
            note_cnt <= '0;
            half_cnt <= '0;
            audio    <= 1'b0;
          end else if (note_end) begin
            note_cnt <= '0;
            half_cnt <= '0;
            audio    <= 1'b0;
            if (step != 2'd3) begin
              step <= step + 2'd1;
            end else if (cur_type == 2'd2) begin
              step <= 2'd0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
            end
          end else begin
            note_cnt <= note_cnt + NW'(1);
            if (code == 8'd0) begin
              audio    <= 1'b0;
              half_cnt <= '0;
            end else if (half_end) begin
              audio    <= ~audio;
              half_cnt <= '0;
            end else begin
              half_cnt <= half_cnt + HW'(1);
            end
          end
        end
        DONE: begin
          if (!en) begin
            state    <= IDLE;
            step     <= 2'd0;
            note_cnt <= '0;
            half_cnt <= '0;
            audio    <= 1'b0;
          end else if (changed) begin
            state    <= PLAY;
            cur_type <= sound_type;
            busy     <= 1'b1;
            step     <= 2'd0;
            note_cnt <= '0;
            half_cnt <= '0;
            audio    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          step  <= 2'd0;
          audio <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboarded bench for tone_sequencer against a time-since-start model.
// Directed scenarios first, then randomized enable/type/reset segments.
module tb_tone_sequencer;

  localparam int NL = 64;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] sound_type;
  logic       audio;
  logic       busy;
  logic [1:0] step;

  int errors;
  int checks;

  logic [3:0] exp_q[$];

  int tbl [4][4] = '{'{40, 40, 0, 0}, '{60, 50, 40, 30},
                     '{30, 60, 30, 60}, '{80, 60, 40, 20}};

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_DONE = 2;

  int mode;
  int t;
  int typ;

  tone_sequencer #(
    .TONE_SCALE(1),
    .NOTE_LEN(NL),
    .HW(8),
    .NW(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .sound_type(sound_type),
    .audio(audio),
    .busy(busy),
    .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // state of the melody after one rising edge with the current inputs
  task automatic model_edge();
    if (!rst) begin
      mode = M_IDLE;
      t    = 0;
    end else begin
      case (mode)
        M_IDLE: if (en) begin
          mode = M_PLAY; t = 0; typ = int'(sound_type);
        end
        M_PLAY: begin
          if (!en) mode = M_IDLE;
          else if (int'(sound_type) != typ) begin
            t = 0; typ = int'(sound_type);
          end else begin
            t++;
            if (typ != 2 && t == 4 * NL) mode = M_DONE;
          end
        end
        default: begin
          if (!en) mode = M_IDLE;
          else if (int'(sound_type) != typ) begin
            mode = M_PLAY; t = 0; typ = int'(sound_type);
          end
        end
      endcase
    end
  endtask

  function automatic logic [3:0] expect_out();
    int s, pos, c;
    logic a;
    if (mode == M_IDLE) return 4'b0000;
    if (mode == M_DONE) return 4'b0011;
    s   = (t / NL) % 4;
    pos = t % NL;
    c   = tbl[typ][s];
    a   = (c != 0) && (((pos / c) % 2) == 1);
    return {a, 1'b1, 2'(s)};
  endfunction

  task automatic cyc(input logic r, input logic e,
                     input logic [1:0] ty, input int n);
    repeat (n) begin
      @(negedge clk);
      rst = r;
      en = e;
      sound_type = ty;
      model_edge();
      exp_q.push_back(expect_out());
    end
  endtask

  // monitor: one expected word per rising edge
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({audio, busy, step} !== e)
          begin
            errors++;
            $display("FAIL out t=%0t got a=%0b b=%0b s=%0d want a=%0b b=%0b s=%0d",
                     $time, audio, busy, step, e[3], e[2], e[1:0]);
          end
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    mode = M_IDLE;
    t = 0;
    typ = 0;
    rst = 1'b0;
    en = 1'b1;
    sound_type = 2'd1;
    cyc(0, 1, 1, 3);
    cyc(1, 1, 1, 300);
    cyc(1, 0, 1, 3);
    cyc(1, 1, 0, 300);
    cyc(1, 0, 0, 2);
    cyc(1, 1, 2, 600);
    cyc(1, 0, 2, 2);
    cyc(1, 1, 1, 100);
    cyc(1, 1, 3, 200);
    cyc(1, 0, 3, 2);
    cyc(1, 1, 1, 90);
    cyc(1, 0, 3, 3);
    cyc(1, 1, 3, 150);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({audio, busy, step} !== 4'b0000) begin
      errors++;
      $display("FAIL async_rst got a=%0b b=%0b s=%0d want 0 0 0",
               audio, busy, step);
    end
    model_edge();
    exp_q.push_back(expect_out());
    cyc(0, 1, 3, 2);
    cyc(1, 1, 3, 50);
    repeat (40) begin
      int n;
      logic r, e;
      logic [1:0] ty;
      n  = $urandom_range(1, 200);
      e  = ($urandom % 5) != 0;
      ty = 2'($urandom % 4);
      r  = ($urandom % 20) != 0;
      cyc(r, e, ty, n);
    end
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
